multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Controller that sequences the shared multiply/divide unit from the execute stage. It detects a mul/div instruction in X, stalls the front of the pipeline, and issues a single-cycle start pulse to the unit. It then waits for the unit's ready flag, or a watchdog timeout, and releases the instruction with its result status into the PW latch. It sits between the DX latch, the multdiv unit and the PW latch, and replaces the ready-delay logic currently held inside PW.

## Interface
- MAX_CYCLES, 40, watchdog limit in cycles spent in WAIT; legal range 1..63.
- clock  in  1  system clock; the block is rising-edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start_mult  in  1  X-stage instruction is mul (ctrlX_startMult).
- start_div  in  1  X-stage instruction is div (ctrlX_startDiv).
- x_ir  in  32  X-stage instruction.
- x_divisor  in  32  X-stage B operand.
- unit_ready  in  1  multdiv result valid.
- unit_exception  in  1  multdiv error flag; sampled with unit_ready.
- ctrl_MULT  out  1  one-cycle start pulse to the unit.
- ctrl_DIV  out  1  one-cycle start pulse to the unit.
- stall  out  1  freezes PC, FD and DX.
- busy  out  1  high in any state other than IDLE.
- pw_load  out  1  load enable for the PW IR register.
- pw_ir  out  32  captured mul/div instruction.
- result_valid  out  1  one-cycle writeback strobe.
- exc_code  out  2  status: 00 ok, 01 unit, 10 divide-by-zero, 11 timeout.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE. Encoding is 2 bits.
- IDLE:
  - When start_mult or start_div is seen, capture x_ir into pw_ir, record the op, and go to LAUNCH.
  - If both starts are high, mult wins.
  - Divide-by-zero check: if the op is div and x_divisor is 0, set exc_code=10 and go directly to DONE. No launch pulse is issued.
- LAUNCH:
  - ctrl_MULT or ctrl_DIV is high for exactly this cycle.
  - The counter clears to 0.
  - Next state is WAIT.
- WAIT:
  - The counter increments each cycle and saturates.
  - If unit_ready is high, set exc_code = unit_exception ? 01 : 00 and go to DONE.
  - Otherwise, if the counter equals MAX_CYCLES-1, set exc_code=11 and go to DONE.
  - unit_ready wins over timeout in the same cycle.
- DONE:
  - result_valid and pw_load are high and stall is low for this cycle.
  - Next state is always IDLE.
- Output equations:
  - stall = start_any in IDLE (combinational), or state is LAUNCH or WAIT.
  - busy is registered from state.
- Starts are ignored in LAUNCH, WAIT and DONE. During the stall the DX latch still holds the same instruction. In DONE, DX is advancing.
- unit_ready outside WAIT is ignored.
- Reset values: state IDLE, counter 0, pw_ir 0, exc_code 00. All pulses, stall and busy are 0.
- Reset mid-operation: the block returns to IDLE immediately and gives no result_valid. The unit is not notified; its next start pulse restarts it.

## Timing
- The start is seen at edge 0 in IDLE. LAUNCH runs in cycle 1. WAIT begins in cycle 2.
- unit_ready seen in WAIT cycle k gives DONE in cycle k+1 and IDLE in k+2.
- Minimum turnaround for a normal op is 4 cycles, with unit_ready in the first WAIT cycle.
- Divide-by-zero takes 2 cycles: IDLE then DONE.
- Timeout: DONE follows MAX_CYCLES WAIT cycles.
- stall is high from the cycle the start is seen through the last WAIT cycle. It is low in DONE.
- A back-to-back mul can start in the IDLE cycle that immediately follows DONE.

## Configuration
- MULTDIV_TIMEOUT_EN defined: the watchdog counter and the exc_code=11 path are present.
- MULTDIV_TIMEOUT_EN undefined: the counter is removed, WAIT exits only on unit_ready, MAX_CYCLES is unused, and exc_code never reads 11.

## Structure
- multdiv_pkg holds:
  - the state enum;
  - the exc_code constants EXC_NONE, EXC_UNIT, EXC_DIV0 and EXC_TIMEOUT;
  - the R-type opcode 00000 and ALU op values mul=00110 and div=00111, used to qualify x_ir.
- Sub-module: sat_counter, a saturating up-counter with synchronous clear and async reset, width $clog2(MAX_CYCLES+1). It is instantiated only under MULTDIV_TIMEOUT_EN.

## Test plan
- mul with unit_ready asserted on the 3rd WAIT cycle:
  - ctrl_MULT pulses in cycle 1;
  - stall is high for cycles 0–4;
  - result_valid is high in cycle 5 with exc_code=00 and pw_ir equal to the mul instruction.
- div with x_divisor=0: no ctrl_DIV pulse; DONE in cycle 1 with exc_code=10; result_valid is high for 1 cycle.
- div with unit_ready and unit_exception=1 in the same cycle: exc_code=01 in DONE.
- MAX_CYCLES=4 with unit_ready held low: with MULTDIV_TIMEOUT_EN, DONE follows 4 WAIT cycles with exc_code=11. Without the macro, the block stays in WAIT indefinitely with stall high.
- Reset asserted asynchronously in the 2nd WAIT cycle:
  - all outputs are 0 immediately;
  - no result_valid appears;
  - a following mul runs normally.
- start_mult and start_div both high in IDLE: only ctrl_MULT pulses. A mul presented in the IDLE cycle right after DONE starts with no bubble.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_UNIT    = 2'b01;
    localparam logic [1:0] EXC_DIV0    = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    // True when ir is an R-type instruction carrying the given ALU op.
    function automatic logic ir_is_op(input logic [31:0] ir, input logic [4:0] alu_op);
        return (ir[31:27] == OPC_RTYPE) && (ir[6:2] == alu_op);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Count up while enabled, holding at all-ones; clear has priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the shared multiply/divide unit from the execute stage: stalls
// the front end, pulses the unit's start, waits for ready (or the watchdog)
// and hands the instruction plus result status to the PW latch.
// Optional watchdog: define MULTDIV_TIMEOUT_EN to build the WAIT-state
// cycle counter and the timeout status path.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] x_ir,
    input  logic [31:0] x_divisor,
    input  logic        unit_ready,
    input  logic        unit_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        busy,
    output logic        pw_load,
    output logic [31:0] pw_ir,
    output logic        result_valid,
    output logic [1:0]  exc_code
);

    // Reject watchdog limits outside the supported counter range.
    if ((MAX_CYCLES == 0) || (MAX_CYCLES > 63)) begin : g_max_cycles_range
        $error("multdiv_sequencer: MAX_CYCLES must be in 1..63");
    end

    state_e      state;
    state_e      state_next;
    logic        op_mult;
    logic        op_mult_next;
    logic [31:0] pw_ir_next;
    logic [1:0]  exc_next;
    logic        mult_req;
    logic        div_req;
    logic        start_any;
    logic        timeout;

    // Starts only count when the X instruction really is the matching op.
    assign mult_req  = start_mult && ir_is_op(x_ir, ALU_MUL);
    assign div_req   = start_div  && ir_is_op(x_ir, ALU_DIV);
    assign start_any = mult_req || div_req;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] wait_count;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == LAUNCH),
        .enable (state == WAIT),
        .count  (wait_count)
    );

    // Fires in the MAX_CYCLES-th WAIT cycle; the count is 0 in the first one.
    assign timeout = (state == WAIT) && (wait_count == CNT_W'(MAX_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and captured-data decode.
    always_comb begin
        state_next   = state;
        op_mult_next = op_mult;
        pw_ir_next   = pw_ir;
        exc_next     = exc_code;
        case (state)
            IDLE: begin
                if (start_any) begin
                    pw_ir_next   = x_ir;
                    op_mult_next = mult_req;
                    if (!mult_req && (x_divisor == '0)) begin
                        exc_next   = EXC_DIV0;
                        state_next = DONE;
                    end else begin
                        exc_next   = EXC_NONE;
                        state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (unit_ready) begin
                    exc_next   = unit_exception ? EXC_UNIT : EXC_NONE;
                    state_next = DONE;
                end else if (timeout) begin
                    exc_next   = EXC_TIMEOUT;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_mult      <= 1'b0;
            pw_ir        <= '0;
            exc_code     <= EXC_NONE;
            ctrl_MULT    <= 1'b0;
            ctrl_DIV     <= 1'b0;
            busy         <= 1'b0;
            pw_load      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            op_mult      <= op_mult_next;
            pw_ir        <= pw_ir_next;
            exc_code     <= exc_next;
            ctrl_MULT    <= (state_next == LAUNCH) && op_mult_next;
            ctrl_DIV     <= (state_next == LAUNCH) && !op_mult_next;
            busy         <= (state_next != IDLE);
            pw_load      <= (state_next == DONE);
            result_valid <= (state_next == DONE);
        end
    end

    // Stall must rise in the same cycle the start is seen, so it is combinational.
    assign stall = ((state == IDLE) && start_any) || (state == LAUNCH) || (state == WAIT);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer. Each operation is
// reduced to a timeline (pulse cycle, DONE cycle, status) derived from the
// block's timing rules and compared cycle by cycle against the DUT.
module tb_multdiv_sequencer;
    import multdiv_pkg::*;

    localparam int unsigned MAXC = 4;
`ifdef MULTDIV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int HANG_WAIT = 1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] x_ir;
    logic [31:0] x_divisor;
    logic        unit_ready;
    logic        unit_exception;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        busy;
    logic        pw_load;
    logic [31:0] pw_ir;
    logic        result_valid;
    logic [1:0]  exc_code;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit is_mul;
        bit both;
        bit div_zero;
        int ready_k;    // WAIT cycle (1-based) with unit_ready; 0 = never
        bit exc_bit;
        int reset_at;   // WAIT cycle in which reset hits; 0 = none
        bit pre_next;   // present a new mul during DONE (must be ignored)
    } op_t;

    multdiv_sequencer #(
        .MAX_CYCLES (MAXC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start_mult     (start_mult),
        .start_div      (start_div),
        .x_ir           (x_ir),
        .x_divisor      (x_divisor),
        .unit_ready     (unit_ready),
        .unit_exception (unit_exception),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .stall          (stall),
        .busy           (busy),
        .pw_load        (pw_load),
        .pw_ir          (pw_ir),
        .result_valid   (result_valid),
        .exc_code       (exc_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_ir(input bit mul);
        logic [31:0] ir;
        ir        = $urandom;
        ir[31:27] = OPC_RTYPE;
        ir[6:2]   = mul ? ALU_MUL : ALU_DIV;
        ir[1:0]   = 2'b00;
        return ir;
    endfunction

    function automatic op_t mk_op(input bit is_mul, input bit both, input bit div_zero,
                                  input int ready_k, input bit exc_bit, input int reset_at,
                                  input bit pre_next);
        op_t s;
        s.is_mul   = is_mul;
        s.both     = both;
        s.div_zero = div_zero;
        s.ready_k  = ready_k;
        s.exc_bit  = exc_bit;
        s.reset_at = reset_at;
        s.pre_next = pre_next;
        return s;
    endfunction

    task automatic check_all_zero(input string where);
        check({where, ".ctrl_MULT"},    ctrl_MULT,    0);
        check({where, ".ctrl_DIV"},     ctrl_DIV,     0);
        check({where, ".stall"},        stall,        0);
        check({where, ".busy"},         busy,         0);
        check({where, ".pw_load"},      pw_load,      0);
        check({where, ".result_valid"}, result_valid, 0);
        check({where, ".pw_ir"},        pw_ir,        0);
        check({where, ".exc_code"},     exc_code,     0);
    endtask

    task automatic check_idle(input string where);
        check({where, ".ctrl_MULT"},    ctrl_MULT,    0);
        check({where, ".ctrl_DIV"},     ctrl_DIV,     0);
        check({where, ".stall"},        stall,        0);
        check({where, ".busy"},         busy,         0);
        check({where, ".result_valid"}, result_valid, 0);
        check({where, ".pw_load"},      pw_load,      0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            start_mult     = 1'b0;
            start_div      = 1'b0;
            x_ir           = $urandom;
            x_divisor      = $urandom;
            unit_ready     = 1'($urandom_range(0, 1));
            unit_exception = 1'($urandom_range(0, 1));
            @(negedge clock);
            check_idle("gap");
        end
    endtask

    // Apply one operation and check every cycle against its expected timeline.
    task automatic run_op(input op_t s);
        logic [31:0] ir;
        logic [31:0] divisor;
        logic [1:0]  exp_exc;
        bit          eff_mul;
        bit          div0;
        int          w;
        int          d;
        int          r;
        eff_mul = s.is_mul || s.both;
        ir      = mk_ir(eff_mul);
        divisor = s.div_zero ? 32'd0 : ($urandom | 32'd1);
        div0    = !eff_mul && (divisor == 0);
        exp_exc = EXC_NONE;
        w       = 0;
        if (div0) begin
            exp_exc = EXC_DIV0;
        end else if ((s.ready_k > 0) && (!TO_EN || (s.ready_k <= int'(MAXC)))) begin
            w       = s.ready_k;
            exp_exc = s.exc_bit ? EXC_UNIT : EXC_NONE;
        end else if (TO_EN) begin
            w       = int'(MAXC);
            exp_exc = EXC_TIMEOUT;
        end else begin
            w = HANG_WAIT;
        end
        d = div0 ? 1 : w + 2;
        r = -1;
        if (!div0 && (s.reset_at > 0) && (s.reset_at <= w)) r = 1 + s.reset_at;
        if (!div0 && (w == HANG_WAIT) && (r < 0)) r = 1 + 6;

        for (int c = 0; c <= d; c++) begin
            @(posedge clock); #1;
            if (c < d) begin
                start_mult = s.is_mul || s.both;
                start_div  = !s.is_mul || s.both;
                x_ir       = ir;
                x_divisor  = divisor;
            end else if (s.pre_next) begin
                start_mult = 1'b1;
                start_div  = 1'b0;
                x_ir       = mk_ir(1'b1);
                x_divisor  = $urandom;
            end else begin
                start_mult = 1'b0;
                start_div  = 1'b0;
                x_ir       = $urandom;
                x_divisor  = $urandom;
            end
            if (!div0 && (c >= 2) && (c < d)) begin
                unit_ready     = (c == s.ready_k + 1);
                unit_exception = unit_ready ? s.exc_bit : 1'($urandom_range(0, 1));
            end else begin
                unit_ready     = 1'($urandom_range(0, 1));
                unit_exception = 1'($urandom_range(0, 1));
            end

            if (c == r) begin
                #1;
                reset      = 1'b1;
                start_mult = 1'b0;
                start_div  = 1'b0;
                unit_ready = 1'b0;
                #1;
                check_all_zero("async_reset");
                @(posedge clock); #1;
                reset = 1'b0;
                @(negedge clock);
                check_idle("post_reset");
                return;
            end

            @(negedge clock);
            check($sformatf("c%0d.stall", c),        stall,        (c < d));
            check($sformatf("c%0d.busy", c),         busy,         (c >= 1));
            check($sformatf("c%0d.ctrl_MULT", c),    ctrl_MULT,    (!div0 && (c == 1) && eff_mul));
            check($sformatf("c%0d.ctrl_DIV", c),     ctrl_DIV,     (!div0 && (c == 1) && !eff_mul));
            check($sformatf("c%0d.result_valid", c), result_valid, (c == d));
            check($sformatf("c%0d.pw_load", c),      pw_load,      (c == d));
            if (c == d) begin
                check("done.exc_code", exc_code, exp_exc);
                check("done.pw_ir",    pw_ir,    ir);
            end
        end
    endtask

    initial begin
        op_t dir [$];
        op_t s;
        reset          = 1'b1;
        start_mult     = 1'b0;
        start_div      = 1'b0;
        x_ir           = '0;
        x_divisor      = '0;
        unit_ready     = 1'b0;
        unit_exception = 1'b0;

        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_idle("after_reset");

        dir.push_back(mk_op(1, 0, 0, 3, 0, 0, 0));   // mul, ready on 3rd WAIT cycle
        dir.push_back(mk_op(0, 0, 1, 1, 0, 0, 0));   // divide by zero
        dir.push_back(mk_op(0, 0, 0, 1, 1, 0, 0));   // div, unit exception
        dir.push_back(mk_op(1, 0, 0, 0, 0, 0, 0));   // never ready: timeout or hang
        dir.push_back(mk_op(1, 0, 0, 5, 0, 2, 0));   // reset in 2nd WAIT cycle
        dir.push_back(mk_op(1, 0, 0, 2, 0, 0, 0));   // normal mul after reset
        dir.push_back(mk_op(1, 1, 1, 1, 0, 0, 1));   // both starts, new mul during DONE
        dir.push_back(mk_op(1, 0, 0, 1, 0, 0, 0));   // back-to-back, minimum turnaround
        dir.push_back(mk_op(1, 0, 1, 2, 1, 0, 0));   // mul with zero B operand

        foreach (dir[i]) begin
            run_op(dir[i]);
            if (!dir[i].pre_next) idle_cycles(1);
        end

        for (int n = 0; n < 40; n++) begin
            s.is_mul   = 1'($urandom_range(0, 1));
            s.both     = ($urandom_range(0, 7) == 0);
            s.div_zero = ($urandom_range(0, 3) == 0);
            s.ready_k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAXC + 2));
            s.exc_bit  = 1'($urandom_range(0, 1));
            s.reset_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            s.pre_next = ($urandom_range(0, 3) == 0);
            run_op(s);
            if (!s.pre_next) idle_cycles(int'($urandom_range(0, 2)));
        end

        idle_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
